spram_arb2: RTL

SPRAM_ARB2 -- requirements
Module: spram_arb2

---
 rtl/spram_arb2.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/spram_arb2.sv
// rtl/spram_arb2.sv - two-requester arbiter in front of a 16x2 single-port RAM
// Optional power-up init sweep is compiled in with SPRAM_ARB2_INIT_EN.
module spram_arb2 #(
  parameter string      PRIORITY  = "RR",
  parameter logic [1:0] INIT_DATA = 2'b00
) (
  input  logic       CLK,
  input  logic       RSTN,
  input  logic       REQ0,
  input  logic       REQ1,
  input  logic       WE0,
  input  logic       WE1,
  input  logic [3:0] AD0,
  input  logic [3:0] AD1,
  input  logic [1:0] DI0,
  input  logic [1:0] DI1,
  output logic       GNT0,
  output logic       GNT1,
  output logic       RVAL0,
  output logic       RVAL1,
  output logic [1:0] DO0,
  output logic [1:0] DO1,
  output logic       BUSY,
  output logic [3:0] RAM_AD,
  output logic [1:0] RAM_DI,
  output logic       RAM_WE,
  output logic       RAM_CE,
  input  logic [1:0] RAM_DO
);

  localparam bit IS_FIXED0 = (PRIORITY == "FIXED0");

  logic       busy;
  logic [3:0] sweep_ad;
  logic       gnt0, gnt1;
  logic       last_q, last_d;
  logic       rval0_q, rval0_d, rval1_q, rval1_d;
  logic [1:0] do0_q, do0_d, do1_q, do1_d;

`ifdef SPRAM_ARB2_INIT_EN
  logic       busy_q, busy_d;
  logic [3:0] sweep_ad_q, sweep_ad_d;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      busy_q     <= 1'b1;
      sweep_ad_q <= 4'd0;
    end else begin
      busy_q     <= busy_d;
      sweep_ad_q <= sweep_ad_d;
    end
  end

  always_comb begin
    busy_d     = busy_q;
    sweep_ad_d = sweep_ad_q;
    if (busy_q) begin
      sweep_ad_d = sweep_ad_q + 4'd1;
      if (sweep_ad_q == 4'hF) busy_d = 1'b0;
    end
  end

  // The sweep flop idles at 1 during reset; BUSY only shows once reset lifts.
  assign busy     = busy_q & RSTN;
  assign sweep_ad = sweep_ad_q;
`else
  assign busy     = 1'b0;
  assign sweep_ad = 4'd0;
`endif

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (RSTN && !busy) begin
      if (REQ0 && REQ1) begin
        if (IS_FIXED0 || last_q) gnt0 = 1'b1;
        else                     gnt1 = 1'b1;
      end else begin
        gnt0 = REQ0;
        gnt1 = REQ1;
      end
    end
  end

  always_comb begin
    RAM_CE = 1'b0;
    RAM_WE = 1'b0;
    RAM_AD = AD0;
    RAM_DI = DI0;
    if (busy) begin
      RAM_CE = 1'b1;
      RAM_WE = 1'b1;
      RAM_AD = sweep_ad;
      RAM_DI = INIT_DATA;
    end else if (gnt0) begin
      RAM_CE = 1'b1;
      RAM_WE = WE0;
    end else if (gnt1) begin
      RAM_CE = 1'b1;
      RAM_WE = WE1;
      RAM_AD = AD1;
      RAM_DI = DI1;
    end
  end

  always_comb begin
    last_d  = last_q;
    if (gnt0)      last_d = 1'b0;
    else if (gnt1) last_d = 1'b1;
    rval0_d = gnt0 & ~WE0;
    rval1_d = gnt1 & ~WE1;
    do0_d   = rval0_d ? RAM_DO : do0_q;
    do1_d   = rval1_d ? RAM_DO : do1_q;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      last_q  <= 1'b1;
      rval0_q <= 1'b0;
      rval1_q <= 1'b0;
      do0_q   <= 2'b00;
      do1_q   <= 2'b00;
    end else begin
      last_q  <= last_d;
      rval0_q <= rval0_d;
      rval1_q <= rval1_d;
      do0_q   <= do0_d;
      do1_q   <= do1_d;
    end
  end

  assign GNT0  = gnt0;
  assign GNT1  = gnt1;
  assign RVAL0 = rval0_q;
  assign RVAL1 = rval1_q;
  assign DO0   = do0_q;
  assign DO1   = do1_q;
  assign BUSY  = busy;

endmodule
